// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard / stall controller:
// controller state encoding and the stall_cause codes it reports.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_I  = 2'd1,
        ST_WAIT_D  = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_LOAD_USE = 3'd1,
        CAUSE_FLAG     = 3'd2,
        CAUSE_BR_REG   = 3'd3,
        CAUSE_IMISS    = 3'd4,
        CAUSE_DMISS    = 3'd5,
        CAUSE_HALT     = 3'd6
    } cause_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Synchronous clear has priority; increment only below the ceiling.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller. Stage controls are purely
// combinational from state and inputs; a single stall cause is selected
// by priority and then decoded into write enables / flush / bubble.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 4,
    parameter int CNT_W        = 16,
    parameter int BR_REG_STALL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_ex_mem_read,
    input  logic              id_ex_reg_write,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_sets_flags,
    input  logic              ex_mem_mem_read,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_rs_used,
    input  logic              if_id_rt_used,
    input  logic              if_id_branch,
    input  logic              if_id_branchr,
    input  logic              branch_taken,
    input  logic              halt,
    input  logic              imiss_req,
    input  logic              dmiss_req,
    input  logic              imiss_done,
    input  logic              dmiss_done,
    output logic              pc_wen,
    output logic              if_id_wen,
    output logic              id_ex_wen,
    output logic              ex_mem_wen,
    output logic              mem_wb_wen,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [2:0]        stall_cause,
    output logic [CNT_W-1:0]  cnt_load_use,
    output logic [CNT_W-1:0]  cnt_flag,
    output logic [CNT_W-1:0]  cnt_miss
);

    state_t state, state_next;
    logic   pend_d, pend_d_next;
    logic   load_use, flag_haz, br_haz;
    cause_t cause;

    // Data / flag / branch-register dependence detection for the ID instruction.
    always_comb begin
        load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                   ((if_id_rs_used && (if_id_rs == id_ex_rd)) ||
                    (if_id_rt_used && (if_id_rt == id_ex_rd)));
        flag_haz = if_id_branch && id_ex_sets_flags;
        br_haz   = (BR_REG_STALL != 0) && if_id_branchr &&
                   ((id_ex_reg_write && (id_ex_rd != '0) && (if_id_rs == id_ex_rd)) ||
                    (ex_mem_mem_read && (ex_mem_rd != '0) && (if_id_rs == ex_mem_rd)));
    end

    // Next state, pending-dmiss latch and prioritised stall cause.
    always_comb begin
        state_next  = state;
        pend_d_next = pend_d;
        cause       = CAUSE_NONE;
        case (state)
            ST_RUN: begin
                if (dmiss_req) begin
                    cause      = CAUSE_DMISS;
                    state_next = ST_WAIT_D;
                end else if (imiss_req) begin
                    cause      = CAUSE_IMISS;
                    state_next = ST_WAIT_I;
                end else if (load_use) begin
                    cause = CAUSE_LOAD_USE;
                end else if (flag_haz) begin
                    cause = CAUSE_FLAG;
                end else if (br_haz) begin
                    cause = CAUSE_BR_REG;
                end else if (halt) begin
                    cause      = CAUSE_HALT;
                    state_next = ST_HALTED;
                end
            end
            ST_WAIT_I: begin
                cause = CAUSE_IMISS;
                if (imiss_done) begin
                    // A data miss raised while fetching is serviced right after.
                    state_next  = (pend_d || dmiss_req) ? ST_WAIT_D : ST_RUN;
                    pend_d_next = 1'b0;
                end else if (dmiss_req) begin
                    pend_d_next = 1'b1;
                end
            end
            ST_WAIT_D: begin
                cause = CAUSE_DMISS;
                if (dmiss_done) begin
                    state_next = ST_RUN;
                end
            end
            ST_HALTED: begin
                cause = CAUSE_HALT;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        // While reset is held the pipeline runs freely with no stall.
        if (!rst_n) begin
            cause = CAUSE_NONE;
        end
    end

    // Decode the selected cause into the stage control signals.
    always_comb begin
        pc_wen       = 1'b1;
        if_id_wen    = 1'b1;
        id_ex_wen    = 1'b1;
        ex_mem_wen   = 1'b1;
        mem_wb_wen   = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        case (cause)
            CAUSE_DMISS: begin
                pc_wen     = 1'b0;
                if_id_wen  = 1'b0;
                id_ex_wen  = 1'b0;
                ex_mem_wen = 1'b0;
                mem_wb_wen = 1'b0;
            end
            CAUSE_IMISS, CAUSE_HALT: begin
                pc_wen      = 1'b0;
                if_id_wen   = 1'b0;
                if_id_flush = 1'b1;
            end
            CAUSE_LOAD_USE, CAUSE_FLAG, CAUSE_BR_REG: begin
                pc_wen       = 1'b0;
                if_id_wen    = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: begin
                // No stall: a taken branch squashes the wrong-path fetch.
                if_id_flush = rst_n && branch_taken;
            end
        endcase
    end

    assign stall_cause = cause;

    // Controller state and pending data-miss flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            pend_d <= 1'b0;
        end else begin
            state  <= state_next;
            pend_d <= pend_d_next;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_load_use (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (cause == CAUSE_LOAD_USE),
        .count (cnt_load_use)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_flag (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (cause == CAUSE_FLAG),
        .count (cnt_flag)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_miss (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   ((cause == CAUSE_IMISS) || (cause == CAUSE_DMISS)),
        .count (cnt_miss)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vectors, a behavioural model checked
// every cycle, plus literal spot checks. A second copy with 2-bit counters
// shares the stimulus to exercise saturation.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_ex_mem_read, id_ex_reg_write, id_ex_sets_flags, ex_mem_mem_read;
    logic [3:0] id_ex_rd, ex_mem_rd, if_id_rs, if_id_rt;
    logic       if_id_rs_used, if_id_rt_used, if_id_branch, if_id_branchr;
    logic       branch_taken, halt, imiss_req, dmiss_req, imiss_done, dmiss_done;

    logic        pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen, if_id_flush, id_ex_bubble;
    logic [2:0]  stall_cause;
    logic [15:0] cnt_load_use, cnt_flag, cnt_miss;

    logic        b_pc_wen, b_if_id_wen, b_id_ex_wen, b_ex_mem_wen, b_mem_wb_wen, b_if_id_flush, b_id_ex_bubble;
    logic [2:0]  b_stall_cause;
    logic [1:0]  b_cnt_load_use, b_cnt_flag, b_cnt_miss;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write), .id_ex_rd(id_ex_rd),
        .id_ex_sets_flags(id_ex_sets_flags), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rs_used(if_id_rs_used), .if_id_rt_used(if_id_rt_used),
        .if_id_branch(if_id_branch), .if_id_branchr(if_id_branchr), .branch_taken(branch_taken), .halt(halt),
        .imiss_req(imiss_req), .dmiss_req(dmiss_req), .imiss_done(imiss_done), .dmiss_done(dmiss_done),
        .pc_wen(pc_wen), .if_id_wen(if_id_wen), .id_ex_wen(id_ex_wen), .ex_mem_wen(ex_mem_wen),
        .mem_wb_wen(mem_wb_wen), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .stall_cause(stall_cause), .cnt_load_use(cnt_load_use), .cnt_flag(cnt_flag), .cnt_miss(cnt_miss)
    );

    hazard_stall_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write), .id_ex_rd(id_ex_rd),
        .id_ex_sets_flags(id_ex_sets_flags), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rs_used(if_id_rs_used), .if_id_rt_used(if_id_rt_used),
        .if_id_branch(if_id_branch), .if_id_branchr(if_id_branchr), .branch_taken(branch_taken), .halt(halt),
        .imiss_req(imiss_req), .dmiss_req(dmiss_req), .imiss_done(imiss_done), .dmiss_done(dmiss_done),
        .pc_wen(b_pc_wen), .if_id_wen(b_if_id_wen), .id_ex_wen(b_id_ex_wen), .ex_mem_wen(b_ex_mem_wen),
        .mem_wb_wen(b_mem_wb_wen), .if_id_flush(b_if_id_flush), .id_ex_bubble(b_id_ex_bubble),
        .stall_cause(b_stall_cause), .cnt_load_use(b_cnt_load_use), .cnt_flag(b_cnt_flag), .cnt_miss(b_cnt_miss)
    );

    logic [9:0] dut_vec, dut2_vec;
    assign dut_vec  = {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen, if_id_flush, id_ex_bubble, stall_cause};
    assign dut2_vec = {b_pc_wen, b_if_id_wen, b_id_ex_wen, b_ex_mem_wen, b_mem_wb_wen, b_if_id_flush, b_id_ex_bubble, b_stall_cause};

    // Model: mode 0 running, 1 waiting on ifetch, 2 waiting on data, 3 halted.
    int   m_mode = 0;
    bit   m_pend = 0;
    int   m_lu = 0, m_flag = 0, m_miss = 0;
    bit   model_valid = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int top;
        top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    // Which stall applies this cycle, by the documented priority order.
    function automatic int model_cause();
        bit lu, fl, br;
        lu = id_ex_mem_read && (id_ex_rd != 0) &&
             ((if_id_rs_used && if_id_rs == id_ex_rd) || (if_id_rt_used && if_id_rt == id_ex_rd));
        fl = if_id_branch && id_ex_sets_flags;
        br = if_id_branchr && ((id_ex_reg_write && id_ex_rd != 0 && if_id_rs == id_ex_rd) ||
                               (ex_mem_mem_read && ex_mem_rd != 0 && if_id_rs == ex_mem_rd));
        if (!rst_n) return 0;
        if (m_mode == 1) return 4;
        if (m_mode == 2) return 5;
        if (m_mode == 3) return 6;
        if (dmiss_req) return 5;
        if (imiss_req) return 4;
        if (lu) return 1;
        if (fl) return 2;
        if (br) return 3;
        if (halt) return 6;
        return 0;
    endfunction

    // What each cause means for the pipeline controls.
    function automatic logic [9:0] model_outs(input int c);
        logic [4:0] wen;
        logic       fl, bb;
        wen = 5'b11111; fl = 1'b0; bb = 1'b0;
        if (c == 5) wen = 5'b00000;
        else if (c == 4 || c == 6) begin wen = 5'b00111; fl = 1'b1; end
        else if (c >= 1 && c <= 3) begin wen = 5'b00111; bb = 1'b1; end
        else fl = rst_n && branch_taken;
        return {wen, fl, bb, 3'(c)};
    endfunction

    // Advance the model on each rising edge.
    always @(posedge clk) begin
        int  c, nmode;
        bit  npend;
        c = model_cause();
        nmode = m_mode;
        npend = m_pend;
        if (!rst_n) begin
            m_mode <= 0; m_pend <= 0; m_lu <= 0; m_flag <= 0; m_miss <= 0;
        end else begin
            if (c == 1) m_lu <= m_lu + 1;
            if (c == 2) m_flag <= m_flag + 1;
            if (c == 4 || c == 5) m_miss <= m_miss + 1;
            if (m_mode == 0) begin
                if (c == 5) nmode = 2;
                else if (c == 4) nmode = 1;
                else if (c == 6) nmode = 3;
            end else if (m_mode == 1) begin
                if (imiss_done) begin
                    nmode = (m_pend || dmiss_req) ? 2 : 0;
                    npend = 0;
                end else if (dmiss_req) npend = 1;
            end else if (m_mode == 2) begin
                if (dmiss_done) nmode = 0;
            end
            m_mode <= nmode;
            m_pend <= npend;
        end
        model_valid <= 1'b1;
    end

    // Compare both DUT copies with the model on every falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("ctrl", dut_vec, model_outs(model_cause()));
            check("ctrl_w2", dut2_vec, model_outs(model_cause()));
            check("cnt_load_use", cnt_load_use, sat(m_lu, 16));
            check("cnt_flag", cnt_flag, sat(m_flag, 16));
            check("cnt_miss", cnt_miss, sat(m_miss, 16));
            check("cnt_load_use_w2", b_cnt_load_use, sat(m_lu, 2));
            check("cnt_flag_w2", b_cnt_flag, sat(m_flag, 2));
            check("cnt_miss_w2", b_cnt_miss, sat(m_miss, 2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_ex_mem_read = 0; id_ex_reg_write = 0; id_ex_rd = 0; id_ex_sets_flags = 0;
        ex_mem_mem_read = 0; ex_mem_rd = 0; if_id_rs = 0; if_id_rt = 0;
        if_id_rs_used = 0; if_id_rt_used = 0; if_id_branch = 0; if_id_branchr = 0;
        branch_taken = 0; halt = 0; imiss_req = 0; dmiss_req = 0; imiss_done = 0; dmiss_done = 0;
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        tick(); tick();
        #3;
        check("reset_pc_wen", pc_wen, 1);
        check("reset_cause", stall_cause, 0);
        check("reset_cnt", cnt_load_use, 0);
        rst_n = 1;
        tick();

        // Load-use on rs.
        id_ex_mem_read = 1; id_ex_rd = 3; if_id_rs = 3; if_id_rs_used = 1;
        #3;
        check("lu_pc_wen", pc_wen, 0);
        check("lu_if_id_wen", if_id_wen, 0);
        check("lu_bubble", id_ex_bubble, 1);
        check("lu_cause", stall_cause, 1);
        tick();
        clear_inputs();
        #3;
        check("lu_cnt", cnt_load_use, 1);
        tick();

        // rd = 0 never creates a dependence.
        id_ex_mem_read = 1; id_ex_rd = 0; if_id_rs = 0; if_id_rs_used = 1;
        #3 check("lu_rd0_cause", stall_cause, 0);
        tick();
        // Load-use through rt, then rt not used.
        clear_inputs();
        id_ex_mem_read = 1; id_ex_rd = 7; if_id_rt = 7; if_id_rt_used = 1; if_id_rs = 7;
        tick();
        if_id_rt_used = 0;
        tick();

        // Flag hazard ignores a taken branch; the following taken branch flushes.
        clear_inputs();
        if_id_branch = 1; id_ex_sets_flags = 1; branch_taken = 1;
        #3;
        check("flag_cause", stall_cause, 2);
        check("flag_noflush", if_id_flush, 0);
        tick();
        id_ex_sets_flags = 0;
        #3;
        check("taken_flush", if_id_flush, 1);
        check("taken_pc_wen", pc_wen, 1);
        tick();
        clear_inputs();
        #3 check("flag_cnt", cnt_flag, 1);
        tick();

        // BR register dependence on EX writer, then on MEM load, then rd = 0.
        if_id_branchr = 1; if_id_rs = 5; id_ex_reg_write = 1; id_ex_rd = 5;
        #3 check("br_cause", stall_cause, 3);
        tick();
        id_ex_reg_write = 0; ex_mem_mem_read = 1; ex_mem_rd = 5;
        tick();
        ex_mem_rd = 0; if_id_rs = 0;
        tick();

        // Load-use outranks flag hazard.
        clear_inputs();
        id_ex_mem_read = 1; id_ex_rd = 2; if_id_rs = 2; if_id_rs_used = 1;
        if_id_branch = 1; id_ex_sets_flags = 1;
        #3 check("prio_cause", stall_cause, 1);
        tick();

        // Data miss: request, four idle wait cycles, done.
        clear_inputs();
        dmiss_req = 1;
        #3;
        check("dmiss_mem_wb_wen", mem_wb_wen, 0);
        check("dmiss_cause", stall_cause, 5);
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) tick();
        dmiss_done = 1;
        tick();
        clear_inputs();
        #3;
        check("dmiss_cnt", cnt_miss, 6);
        check("dmiss_back_run", stall_cause, 0);
        tick();

        // Instruction miss with a data miss arriving while waiting.
        imiss_req = 1;
        #3;
        check("imiss_cause", stall_cause, 4);
        check("imiss_flush", if_id_flush, 1);
        tick();
        clear_inputs(); dmiss_req = 1;
        tick();
        clear_inputs();
        tick();
        imiss_done = 1;
        tick();
        clear_inputs();
        #3 check("nested_wait_d", stall_cause, 5);
        tick();
        dmiss_done = 1;
        tick();
        clear_inputs();

        // Stray done pulses in RUN do nothing.
        dmiss_done = 1; imiss_done = 1;
        #3 check("lone_done_wen", mem_wb_wen, 1);
        tick();
        clear_inputs();
        #3 check("lone_done_cnt", cnt_miss, 12);
        tick();

        // Five load-use stalls saturate the 2-bit counter.
        id_ex_mem_read = 1; id_ex_rd = 9; if_id_rt = 9; if_id_rt_used = 1;
        for (int i = 0; i < 5; i++) tick();
        clear_inputs();
        #3;
        check("sat_w2", b_cnt_load_use, 3);
        check("sat_w16", cnt_load_use, 8);
        tick();

        // Halt, stay halted despite a miss request, then reset out.
        halt = 1;
        #3;
        check("halt_cause", stall_cause, 6);
        check("halt_flush", if_id_flush, 1);
        tick();
        clear_inputs(); imiss_req = 1;
        #3 check("halted_pc_wen", pc_wen, 0);
        tick();
        clear_inputs();
        tick();
        rst_n = 0;
        #3;
        check("rst_halt_cause", stall_cause, 0);
        check("rst_halt_pc_wen", pc_wen, 1);
        tick();
        rst_n = 1;
        #3;
        check("post_rst_cause", stall_cause, 0);
        check("post_rst_cnt_miss", cnt_miss, 0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
